// File: rtl/car_collision.sv
// Collision checker between the frog and six lane cars: snapshots positions per frame,
// scans one car per cycle, and runs the lives/respawn/grace/game-over sequence.
module car_collision #(
  parameter int CAR_W        = 32,
  parameter int FROG_W       = 16,
  parameter int FROG_H       = 16,
  parameter int LANE_Y_BASE  = 64,
  parameter int LANE_PITCH   = 48,
  parameter int LANE_H       = 32,
  parameter int LIVES_INIT   = 3,
  parameter int GRACE_FRAMES = 60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_car_x1,
  input  logic [9:0] i_car_x2,
  input  logic [9:0] i_car_x3,
  input  logic [9:0] i_car_x4,
  input  logic [9:0] i_car_x5,
  input  logic [9:0] i_car_x6,
  input  logic [9:0] i_frog_x,
  input  logic [9:0] i_frog_y,
  input  logic       i_frame_tick,
  input  logic       i_respawn_ack,
  input  logic       i_restart,
  output logic       o_hit,
  output logic [2:0] o_hit_idx,
  output logic       o_respawn_req,
  output logic [1:0] o_lives,
  output logic       o_game_over,
  output logic [2:0] o_state
);

  localparam int GW = (GRACE_FRAMES < 1) ? 1 : $clog2(GRACE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_HIT, S_WAIT_ACK, S_GRACE, S_OVER
  } state_t;

  // Handshake: o_respawn_req rises on entry to WAIT_ACK and stays high until an
  // i_respawn_ack is seen from the second WAIT_ACK cycle onward; it drops the cycle after.
  state_t        r_state, w_next;
  logic [9:0]    r_car [6];
  logic [9:0]    r_fx, r_fy;
  logic [2:0]    r_idx;
  logic          r_hit;
  logic [2:0]    r_hit_idx;
  logic          r_req;
  logic          r_armed;
  logic [1:0]    r_lives;
  logic [GW-1:0] r_grace;

  logic [9:0]  w_sel_x, w_dx1, w_dx2;
  logic [10:0] w_top, w_fy11;
  logic        w_row, w_col, w_overlap;

  always_comb begin
    w_sel_x = r_car[0];
    case (r_idx)
      3'd1:    w_sel_x = r_car[1];
      3'd2:    w_sel_x = r_car[2];
      3'd3:    w_sel_x = r_car[3];
      3'd4:    w_sel_x = r_car[4];
      3'd5:    w_sel_x = r_car[5];
      default: w_sel_x = r_car[0];
    endcase
  end

  // 11-bit row compare avoids overflow of frog_y+FROG_H; 10-bit column differences wrap on purpose.
  assign w_top     = 11'(LANE_Y_BASE + LANE_PITCH * int'(r_idx));
  assign w_fy11    = {1'b0, r_fy};
  assign w_row     = (w_fy11 < w_top + 11'(LANE_H)) && (w_fy11 + 11'(FROG_H) > w_top);
  assign w_dx1     = r_fx - w_sel_x;
  assign w_dx2     = w_sel_x - r_fx;
  assign w_col     = (w_dx1 < 10'(CAR_W)) || (w_dx2 < 10'(FROG_W));
  assign w_overlap = w_row && w_col;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (i_frame_tick) w_next = S_SCAN;
      S_SCAN:     if (w_overlap) w_next = S_HIT;
                  else if (r_idx == 3'd5) w_next = S_IDLE;
      S_HIT:      w_next = (r_lives == 2'd0) ? S_OVER : S_WAIT_ACK;
      S_WAIT_ACK: if (r_armed && i_respawn_ack) w_next = S_GRACE;
      S_GRACE:    if (r_grace == '0) w_next = S_IDLE;
      S_OVER:     w_next = S_OVER;
      default:    w_next = S_IDLE;
    endcase
    if (i_restart) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_car     <= '{default: '0};
      r_fx      <= '0;
      r_fy      <= '0;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_req     <= 1'b0;
      r_armed   <= 1'b0;
      r_lives   <= 2'(LIVES_INIT);
      r_grace   <= '0;
    end else begin
      r_state <= w_next;
      r_hit   <= 1'b0;
      if (i_restart) begin
        r_lives <= 2'(LIVES_INIT);
        r_req   <= 1'b0;
        r_armed <= 1'b0;
        r_grace <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (i_frame_tick) begin
            r_car <= '{i_car_x1, i_car_x2, i_car_x3, i_car_x4, i_car_x5, i_car_x6};
            r_fx  <= i_frog_x;
            r_fy  <= i_frog_y;
            r_idx <= '0;
          end
          S_SCAN: if (w_overlap) begin
            r_hit     <= 1'b1;
            r_hit_idx <= r_idx;
            r_lives   <= (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
          S_HIT: if (r_lives != 2'd0) begin
            r_req   <= 1'b1;
            r_armed <= 1'b0;
          end
          S_WAIT_ACK: if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (i_respawn_ack) begin
            r_req   <= 1'b0;
            r_armed <= 1'b0;
            r_grace <= GW'(GRACE_FRAMES);
          end
          S_GRACE: if (i_frame_tick && r_grace != '0) r_grace <= r_grace - GW'(1);
          default: ;
        endcase
      end
    end
  end

  assign o_hit         = r_hit;
  assign o_hit_idx     = r_hit_idx;
  assign o_respawn_req = r_req;
  assign o_lives       = r_lives;
  assign o_game_over   = (r_state == S_OVER);
  assign o_state       = r_state;

endmodule

// File: tb/tb_car_collision.sv
// Bench for car_collision: directed frames from the game rules plus randomized frames
// checked against a frame-level model of lives, grace and game-over.
module tb_car_collision;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] car [6];
  logic [9:0] fx, fy;
  logic       frame_tick = 1'b0, respawn_ack = 1'b0, restart = 1'b0;
  logic       o_hit, o_respawn_req, o_game_over;
  logic [2:0] o_hit_idx, o_state;
  logic [1:0] o_lives;

  int checks = 0;
  int errors = 0;

  // Frame-level model state
  int m_lives, m_grace, m_hit_idx;
  bit m_over, m_req;
  logic [2:0] exp_q[$];

  car_collision dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_car_x1(car[0]), .i_car_x2(car[1]), .i_car_x3(car[2]),
    .i_car_x4(car[3]), .i_car_x5(car[4]), .i_car_x6(car[5]),
    .i_frog_x(fx), .i_frog_y(fy),
    .i_frame_tick(frame_tick), .i_respawn_ack(respawn_ack), .i_restart(restart),
    .o_hit(o_hit), .o_hit_idx(o_hit_idx), .o_respawn_req(o_respawn_req),
    .o_lives(o_lives), .o_game_over(o_game_over), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lowest-index car whose rectangle touches the frog; -1 if none.
  function automatic int first_hit();
    for (int k = 0; k < 6; k++) begin
      int top = 64 + 48 * k;
      int y = int'(fy);
      int x = int'(fx);
      int c = int'(car[k]);
      bit row = (y < top + 32) && (y + 16 > top);
      bit col = (((x - c + 1024) % 1024) < 32) || (((c - x + 1024) % 1024) < 16);
      if (row && col) return k;
    end
    return -1;
  endfunction

  task automatic model_reset(input bit clear_idx);
    m_lives = 3; m_grace = 0; m_over = 0; m_req = 0;
    if (clear_idx) m_hit_idx = 0;
    exp_q.delete();
  endtask

  // One frame: tick, watch cycles N+1..N+9 for the hit pulse, then compare to the model.
  task automatic run_frame(input string tag, input int ack_j);
    int exp_k, hits, first_j;
    exp_k = (m_over || m_grace > 0) ? -1 : first_hit();
    if (m_grace > 0) m_grace--;
    if (exp_k >= 0) exp_q.push_back(3'(exp_k));
    hits = 0; first_j = -1;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      respawn_ack = (j == ack_j);
      @(negedge clk);
      if (o_hit === 1'b1) begin
        hits++;
        if (first_j < 0) begin
          first_j = j;
          if (exp_q.size() > 0) check({tag, "_idx"}, 32'(o_hit_idx), 32'(exp_q.pop_front()));
          else check({tag, "_unexpected_hit"}, 32'(o_hit), 32'd0);
        end
      end
      @(posedge clk); #1;
    end
    respawn_ack = 1'b0;
    exp_q.delete();
    check({tag, "_hits"}, 32'(hits), (exp_k >= 0) ? 32'd1 : 32'd0);
    check({tag, "_latency"}, 32'(first_j), (exp_k >= 0) ? 32'(2 + exp_k) : 32'hFFFF_FFFF);
    if (exp_k >= 0) begin
      m_lives   = (m_lives > 0) ? m_lives - 1 : 0;
      m_hit_idx = exp_k;
      if (m_lives == 0) m_over = 1; else m_req = 1;
    end
    check({tag, "_lives"}, 32'(o_lives), 32'(m_lives));
    check({tag, "_over"}, 32'(o_game_over), 32'(m_over));
    check({tag, "_req"}, 32'(o_respawn_req), 32'(m_req));
    check({tag, "_held_idx"}, 32'(o_hit_idx), 32'(m_hit_idx));
  endtask

  task automatic do_respawn(input string tag);
    @(negedge clk);
    check({tag, "_req_before_ack"}, 32'(o_respawn_req), 32'd1);
    @(posedge clk); #1 respawn_ack = 1'b1;
    @(posedge clk); #1 respawn_ack = 1'b0;
    @(negedge clk);
    check({tag, "_req_after_ack"}, 32'(o_respawn_req), 32'd0);
    m_req = 0; m_grace = 60;
  endtask

  task automatic do_restart(input string tag);
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    model_reset(1'b0);
    @(negedge clk);
    check({tag, "_lives"}, 32'(o_lives), 32'd3);
    check({tag, "_over"}, 32'(o_game_over), 32'd0);
    check({tag, "_req"}, 32'(o_respawn_req), 32'd0);
    check({tag, "_idx_kept"}, 32'(o_hit_idx), 32'(m_hit_idx));
  endtask

  task automatic set_scene(input int x, input int y, input int cx);
    fx = 10'(x); fy = 10'(y);
    for (int k = 0; k < 6; k++) car[k] = 10'(cx);
  endtask

  initial begin
    set_scene(500, 0, 900);
    model_reset(1'b1);
    #23 rst_n = 1'b1;
    @(negedge clk);
    check("rst_hit", 32'(o_hit), 32'd0);
    check("rst_hit_idx", 32'(o_hit_idx), 32'd0);
    check("rst_req", 32'(o_respawn_req), 32'd0);
    check("rst_lives", 32'(o_lives), 32'd3);
    check("rst_over", 32'(o_game_over), 32'd0);

    // Basic hit on car 1; an ack in the first WAIT_ACK cycle must be ignored.
    set_scene(100, 64, 600); car[0] = 10'd90;
    run_frame("basic", 3);
    do_respawn("basic");

    // Frog keeps overlapping: 60 grace frames silent, the 61st hits.
    for (int i = 0; i < 61; i++) run_frame("grace", 0);
    check("grace_lives", 32'(o_lives), 32'd1);
    do_respawn("grace2");
    set_scene(500, 0, 900);
    for (int i = 0; i < 60; i++) run_frame("grace_idle", 0);

    // Wrap-around overlap on car 2 takes the last life.
    set_scene(1020, 112, 500); car[1] = 10'd5;
    run_frame("wrap", 0);
    check("wrap_over", 32'(o_game_over), 32'd1);
    run_frame("over_tick", 0);
    do_restart("restart");

    // Every car at the frog's x, but only lane 3 covers its y.
    set_scene(300, 208, 300);
    run_frame("multi", 0);

    // Asynchronous reset while waiting for the ack.
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_hit", 32'(o_hit), 32'd0);
    check("arst_idx", 32'(o_hit_idx), 32'd0);
    check("arst_req", 32'(o_respawn_req), 32'd0);
    check("arst_lives", 32'(o_lives), 32'd3);
    check("arst_over", 32'(o_game_over), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_reset(1'b1);

    // Randomized frames, with overlapping cars planted half the time.
    for (int i = 0; i < 150; i++) begin
      int k;
      fx = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) fy = 10'(64 + 48 * $urandom_range(0, 5) - 15 + $urandom_range(0, 60));
      else fy = 10'($urandom_range(0, 1023));
      for (int c = 0; c < 6; c++) car[c] = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 5);
        car[k] = fx - 10'($urandom_range(0, 40));
      end
      run_frame("rnd", 0);
      if (m_req) do_respawn("rnd");
      if (m_over) do_restart("rnd_restart");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
